legv8_control_fsm: RTL and testbench

Multi-cycle control unit for the LEGv8 64-bit datapath. It sequences fetch, decode, execute and memory phases by driving the datapath's 40-bit ControlWord and 64-bit constant inputs. It consumes the instruction register and ALU status fed back from the datapath, and inserts wait states until memory acknowledges. It replaces the hand-written control words of bench-driven bring-up and is the first block that lets the datapath run programs autonomously.

---
 rtl/legv8_control_fsm.sv | 157 +++++++++++++++
 tb/tb_legv8_control_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_fsm.sv
// Multi-cycle control unit for the LEGv8 datapath: sequences FETCH/DECODE/EXEC/MEM,
// drives the 40-bit control word combinationally and registers the decoded immediate.
module legv8_control_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_out,
  input  logic [4:0]  status,
  input  logic        mem_ready,
  output logic [39:0] ControlWord,
  output logic [63:0] constant,
  output logic [2:0]  state,
  output logic        halted
);

  localparam int unsigned CW_W  = 40;
  localparam int unsigned K_W   = 64;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FS_W  = 5;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [FS_W-1:0] FS_AND  = 5'b00000;
  localparam logic [FS_W-1:0] FS_ORR  = 5'b00100;
  localparam logic [FS_W-1:0] FS_ADD  = 5'b01000;
  localparam logic [FS_W-1:0] FS_SUB  = 5'b01001;
  localparam logic [FS_W-1:0] FS_PASS = 5'b01100;

  localparam logic [1:0] SZ_32 = 2'b10;
  localparam logic [1:0] SZ_64 = 2'b11;
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;

  // Opcode classification straight from the instruction register
  logic is_add, is_sub, is_and, is_orr, is_addi, is_subi;
  logic is_ldur, is_stur, is_b, is_cbz, is_rtype, is_itype;
  assign is_add   = (IR_out[31:21] == 11'b10001011000);
  assign is_sub   = (IR_out[31:21] == 11'b11001011000);
  assign is_and   = (IR_out[31:21] == 11'b10001010000);
  assign is_orr   = (IR_out[31:21] == 11'b10101010000);
  assign is_addi  = (IR_out[31:22] == 10'b1001000100);
  assign is_subi  = (IR_out[31:22] == 10'b1101000100);
  assign is_ldur  = (IR_out[31:21] == 11'b11111000010);
  assign is_stur  = (IR_out[31:21] == 11'b11111000000);
  assign is_b     = (IR_out[31:26] == 6'b000101);
  assign is_cbz   = (IR_out[31:24] == 8'b10110100);
  assign is_rtype = is_add | is_sub | is_and | is_orr;
  assign is_itype = is_addi | is_subi;

  // Only the zero flag steers control; the other flags belong to the datapath
  logic status_unused;
  assign status_unused = ^status[4:1];

  logic [REG_W-1:0] rd, rn, rm;
  assign rd = IR_out[4:0];
  assign rn = IR_out[9:5];
  assign rm = IR_out[20:16];

  // Immediate extraction, captured at the end of DECODE
  logic [K_W-1:0] imm_next;
  always_comb begin
    imm_next = '0;
    if (is_itype)              imm_next = K_W'(IR_out[21:10]);
    else if (is_ldur | is_stur) imm_next = {{55{IR_out[20]}}, IR_out[20:12]};
    else if (is_b)             imm_next = {{36{IR_out[25]}}, IR_out[25:0], 2'b00};
    else if (is_cbz)           imm_next = {{43{IR_out[23]}}, IR_out[23:5], 2'b00};
  end

  logic [2:0]       state_next;
  logic [REG_W-1:0] da, sa, sb;
  logic [FS_W-1:0]  fs;
  logic [1:0]       size, pc_sel;
  logic reg_write, b_sel, c0, status_load, mem_write, mem_read;
  logic ir_load, addr_sel, d_sel, bus_drive;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      halted   <= 1'b0;
      constant <= '0;
    end else begin
      state  <= state_next;
      halted <= (state_next == S_HALT);
      if (state == S_DECODE) constant <= imm_next;
    end
  end

  // Next state and control fields
  always_comb begin
    state_next  = state;
    da = '0; sa = '0; sb = '0; fs = FS_AND;
    size = 2'b00; pc_sel = PC_HOLD;
    reg_write = 1'b0; b_sel = 1'b0; c0 = 1'b0; status_load = 1'b0;
    mem_write = 1'b0; mem_read = 1'b0; ir_load = 1'b0;
    addr_sel = 1'b0; d_sel = 1'b0; bus_drive = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        addr_sel = 1'b1;
        size     = SZ_32;
        ir_load  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        state_next = S_FETCH;
        if (is_rtype | is_itype) begin
          da = rd; sa = rn; sb = rm;
          reg_write = 1'b1; status_load = 1'b1; pc_sel = PC_INC;
          b_sel = is_itype;
          if (is_add | is_addi)      fs = FS_ADD;
          else if (is_sub | is_subi) begin fs = FS_SUB; c0 = 1'b1; end
          else if (is_orr)           fs = FS_ORR;
          else                       fs = FS_AND;
        end else if (is_ldur | is_stur) begin
          state_next = S_MEM;
        end else if (is_b) begin
          pc_sel = PC_REL;
        end else if (is_cbz) begin
          sb = rd; fs = FS_PASS;
          pc_sel = status[0] ? PC_REL : PC_INC;
        end else begin
          state_next = S_HALT;
        end
      end
      S_MEM: begin
        sa = rn; b_sel = 1'b1; fs = FS_ADD; size = SZ_64;
        if (is_stur) begin
          mem_write = 1'b1; sb = rd; bus_drive = 1'b1;
        end else begin
          mem_read = 1'b1; d_sel = 1'b1; da = rd;
          reg_write = mem_ready;
        end
        if (mem_ready) begin
          pc_sel     = PC_INC;
          state_next = S_FETCH;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Reset gates the word so no memory access can start while held
  always_comb begin
    ControlWord = '0;
    if (reset)
      ControlWord = CW_W'({6'b0, bus_drive, d_sel, addr_sel, ir_load, pc_sel, size,
                           mem_read, mem_write, status_load, c0, fs, b_sel, reg_write,
                           sb, sa, da});
  end

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Directed bench for legv8_control_fsm: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_legv8_control_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR_out;
  logic [4:0]  status;
  logic        mem_ready;
  logic [39:0] ControlWord;
  logic [63:0] constant;
  logic [2:0]  state;
  logic        halted;

  legv8_control_fsm dut (
    .clock(clock), .reset(reset), .IR_out(IR_out), .status(status),
    .mem_ready(mem_ready), .ControlWord(ControlWord), .constant(constant),
    .state(state), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [39:0] cw;
    logic [2:0]  st;
    logic        chk_k;
    logic [63:0] k;
    logic        hl;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cycle = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        finish_req = 1'b0;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [39:0] mk(input logic [4:0] da, input logic [4:0] sa,
      input logic [4:0] sb, input logic rw, input logic bs, input logic [4:0] fs,
      input logic c0, input logic sl, input logic mw, input logic mrd,
      input logic [1:0] sz, input logic [1:0] pc, input logic irl, input logic asel,
      input logic dsel, input logic bus);
    mk = {6'b0, bus, dsel, asel, irl, pc, sz, mrd, mw, sl, c0, fs, bs, rw, sb, sa, da};
  endfunction

  // Monitor: compare every expectation tagged for the current cycle
  always @(negedge clock) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
      e = sb_q.pop_front();
      n_chk++;
      if (e.cyc != cycle) begin
        n_err++; $display("FAIL %s stale: cycle %0d expected %0d", e.name, cycle, e.cyc);
      end
      n_chk++;
      if (ControlWord !== e.cw) begin
        n_err++; $display("FAIL %s cw: got %h want %h", e.name, ControlWord, e.cw);
      end
      n_chk++;
      if (state !== e.st) begin
        n_err++; $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
      end
      n_chk++;
      if (halted !== e.hl) begin
        n_err++; $display("FAIL %s halted: got %b want %b", e.name, halted, e.hl);
      end
      if (e.chk_k) begin
        n_chk++;
        if (constant !== e.k) begin
          n_err++; $display("FAIL %s constant: got %h want %h", e.name, constant, e.k);
        end
      end
    end
    if (finish_req) begin
      n_chk++;
      if (sb_q.size() != 0) begin
        n_err++; $display("FAIL leftover: got %0d pending want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
  end

  task automatic step(input string name, input logic rst, input logic [31:0] ir,
      input logic [4:0] st_in, input logic mr, input logic [39:0] cw, input logic [2:0] st,
      input logic chk_k, input logic [63:0] k, input logic hl);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; IR_out = ir; status = st_in; mem_ready = mr;
    e.cyc = cycle; e.name = name; e.cw = cw; e.st = st;
    e.chk_k = chk_k; e.k = k; e.hl = hl;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] f_rdy, f_wait, orr_ex, addi_ex, ld_wait, ld_done;
    logic [39:0] cbz_t, cbz_f, b_ex, st_wait;
    logic [31:0] ir_orr, ir_addi, ir_ldur, ir_cbz, ir_b, ir_stur, ir_bad;

    f_rdy   = mk(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 1, 2'b10, 2'b00, 1, 1, 0, 0);
    f_wait  = mk(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 1, 2'b10, 2'b00, 0, 1, 0, 0);
    orr_ex  = mk(0, 31, 1, 1, 0, 5'b00100, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
    addi_ex = mk(1, 2, 0, 1, 1, 5'b01000, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
    ld_wait = mk(2, 31, 0, 0, 1, 5'b01000, 0, 0, 0, 1, 2'b11, 2'b00, 0, 0, 1, 0);
    ld_done = mk(2, 31, 0, 1, 1, 5'b01000, 0, 0, 0, 1, 2'b11, 2'b01, 0, 0, 1, 0);
    cbz_t   = mk(0, 0, 3, 0, 0, 5'b01100, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0);
    cbz_f   = mk(0, 0, 3, 0, 0, 5'b01100, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
    b_ex    = mk(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0);
    st_wait = mk(0, 1, 5, 0, 1, 5'b01000, 0, 0, 1, 0, 2'b11, 2'b00, 0, 0, 0, 1);

    ir_orr  = {11'b10101010000, 5'd1, 6'd0, 5'd31, 5'd0};
    ir_addi = {10'b1001000100, 12'd24, 5'd2, 5'd1};
    ir_ldur = {11'b11111000010, 9'h1F8, 2'b00, 5'd31, 5'd2};
    ir_cbz  = {8'b10110100, 19'd4, 5'd3};
    ir_b    = {6'b000101, 26'h3FF_FFFF};
    ir_stur = {11'b11111000000, 9'd16, 2'b00, 5'd1, 5'd5};
    ir_bad  = 32'hFFFF_FFFF;

    reset = 1'b1; IR_out = '0; status = '0; mem_ready = 1'b0;
    #2 reset = 1'b0;

    step("rst0", 0, ir_orr, 0, 1, '0, 0, 1, 0, 0);
    step("rst1", 0, ir_orr, 0, 1, '0, 0, 1, 0, 0);
    step("orr_f", 1, ir_orr, 0, 1, f_rdy, 0, 1, 0, 0);
    step("orr_d", 1, ir_orr, 0, 0, '0, 1, 0, 0, 0);
    step("orr_e", 1, ir_orr, 5'h1F, 0, orr_ex, 2, 1, 0, 0);

    step("addi_f", 1, ir_addi, 0, 1, f_rdy, 0, 0, 0, 0);
    step("addi_d", 1, ir_addi, 0, 1, '0, 1, 0, 0, 0);
    step("addi_e", 1, ir_addi, 0, 1, addi_ex, 2, 1, 64'd24, 0);

    step("ld_f", 1, ir_ldur, 0, 1, f_rdy, 0, 0, 0, 0);
    step("ld_d", 1, ir_ldur, 0, 1, '0, 1, 0, 0, 0);
    step("ld_e", 1, ir_ldur, 0, 1, '0, 2, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    step("ld_m0", 1, ir_ldur, 0, 0, ld_wait, 3, 0, 0, 0);
    step("ld_m1", 1, ir_ldur, 0, 0, ld_wait, 3, 0, 0, 0);
    step("ld_m2", 1, ir_ldur, 0, 1, ld_done, 3, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);

    step("cbz_fw", 1, ir_cbz, 0, 0, f_wait, 0, 0, 0, 0);
    step("cbz_f", 1, ir_cbz, 0, 1, f_rdy, 0, 0, 0, 0);
    step("cbz_d", 1, ir_cbz, 0, 1, '0, 1, 0, 0, 0);
    step("cbz_et", 1, ir_cbz, 5'b00001, 1, cbz_t, 2, 1, 64'd16, 0);
    step("cbz2_f", 1, ir_cbz, 0, 1, f_rdy, 0, 0, 0, 0);
    step("cbz2_d", 1, ir_cbz, 0, 1, '0, 1, 0, 0, 0);
    step("cbz_ef", 1, ir_cbz, 5'b11110, 1, cbz_f, 2, 1, 64'd16, 0);

    step("b_f", 1, ir_b, 0, 1, f_rdy, 0, 0, 0, 0);
    step("b_d", 1, ir_b, 0, 1, '0, 1, 0, 0, 0);
    step("b_e", 1, ir_b, 0, 1, b_ex, 2, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);

    step("st_f", 1, ir_stur, 0, 1, f_rdy, 0, 0, 0, 0);
    step("st_d", 1, ir_stur, 0, 1, '0, 1, 0, 0, 0);
    step("st_e", 1, ir_stur, 0, 1, '0, 2, 1, 64'd16, 0);
    step("st_m0", 1, ir_stur, 0, 0, st_wait, 3, 0, 0, 0);
    step("st_rst", 0, ir_stur, 0, 0, '0, 0, 1, 0, 0);
    step("st_rel0", 1, ir_bad, 0, 0, f_wait, 0, 1, 0, 0);
    step("st_rel1", 1, ir_bad, 0, 0, f_wait, 0, 1, 0, 0);

    step("bad_f", 1, ir_bad, 0, 1, f_rdy, 0, 0, 0, 0);
    step("bad_d", 1, ir_bad, 0, 1, '0, 1, 0, 0, 0);
    step("bad_e", 1, ir_bad, 0, 1, '0, 2, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      step("halt", 1, ir_bad, 5'(i), 1'(i & 1), '0, 7, 1, 0, 1);
    step("halt_rst", 0, ir_bad, 0, 1, '0, 0, 1, 0, 0);
    step("halt_rel", 1, ir_orr, 0, 1, f_rdy, 0, 1, 0, 0);

    @(posedge clock);
    #1 finish_req = 1'b1;
  end

endmodule
